// File: rtl/spi_xfer_sequencer_if.sv
// Byte-stream and SPI-master handshake bundle for spi_xfer_sequencer.
// master: the sequencer side; slave: the system/SPI-master side.
interface spi_xfer_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  spi_start;
  logic [DATA_WIDTH-1:0] spi_data_in;
  logic                  spi_done;
  logic [DATA_WIDTH-1:0] spi_data_out;

  modport master (
    input  tx_data, tx_valid, rx_ready, spi_done, spi_data_out,
    output tx_ready, rx_data, rx_valid, spi_start, spi_data_in
  );

  modport slave (
    output tx_data, tx_valid, rx_ready, spi_done, spi_data_out,
    input  tx_ready, rx_data, rx_valid, spi_start, spi_data_in
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// TX/RX byte FIFOs around a one-transfer-in-flight SPI master handshake.
// Define SPI_SEQ_TIMEOUT_EN to build the WAIT-state watchdog and timeout_err.
module spi_xfer_sequencer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  spi_xfer_sequencer_if.master        bus,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        timeout_err
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t                state_q, state_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      tx_rd, tx_wr, rx_rd, rx_wr, rx_rd_d;
  logic [CNT_W-1:0]      tx_cnt_d, rx_cnt_d;
  logic [DATA_WIDTH-1:0] rx_head_d;
  logic                  launch, rx_push, tx_push, rx_pop;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = 16;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_fire;
`endif

  assign tx_push = bus.tx_valid && bus.tx_ready;
  assign rx_pop  = bus.rx_valid && bus.rx_ready;

  // Next state; gap/watchdog counters return to zero whenever their state is left
  always_comb begin
    state_d = state_q;
    gap_d   = '0;
    launch  = 1'b0;
    rx_push = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    wd_d    = '0;
    wd_fire = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // RX slot is reserved here, so the WAIT-state push can never overflow
        if (tx_level != '0 && rx_level != CNT_W'(FIFO_DEPTH)) begin
          launch  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.spi_done) begin
          rx_push = 1'b1;
          state_d = GAP;
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          wd_fire = 1'b1;
          state_d = GAP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                 gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO occupancy and RX head after this edge, used to register the status outputs
  always_comb begin
    tx_cnt_d = tx_level;
    if (tx_push && !launch)      tx_cnt_d = tx_level + CNT_W'(1);
    else if (!tx_push && launch) tx_cnt_d = tx_level - CNT_W'(1);
    rx_cnt_d = rx_level;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_level + CNT_W'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_level - CNT_W'(1);
    rx_rd_d   = rx_pop ? rx_rd + PTR_W'(1) : rx_rd;
    rx_head_d = (rx_push && rx_wr == rx_rd_d) ? bus.spi_data_out : rx_mem[rx_rd_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      gap_q           <= '0;
      tx_rd           <= '0;
      tx_wr           <= '0;
      rx_rd           <= '0;
      rx_wr           <= '0;
      tx_level        <= '0;
      rx_level        <= '0;
      bus.tx_ready    <= 1'b1;
      bus.rx_valid    <= 1'b0;
      bus.rx_data     <= '0;
      bus.spi_start   <= 1'b0;
      bus.spi_data_in <= '0;
      busy            <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      tx_level      <= tx_cnt_d;
      rx_level      <= rx_cnt_d;
      rx_rd         <= rx_rd_d;
      if (tx_push) tx_wr <= tx_wr + PTR_W'(1);
      if (launch)  tx_rd <= tx_rd + PTR_W'(1);
      if (rx_push) rx_wr <= rx_wr + PTR_W'(1);
      bus.tx_ready  <= (tx_cnt_d != CNT_W'(FIFO_DEPTH));
      bus.rx_valid  <= (rx_cnt_d != '0);
      bus.rx_data   <= rx_head_d;
      bus.spi_start <= launch;
      if (launch) bus.spi_data_in <= tx_mem[tx_rd];
      busy          <= (state_d != IDLE) || (tx_cnt_d != '0);
    end
  end

  // FIFO storage needs no reset; occupancy alone defines what is valid
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.tx_data;
    if (rx_push) rx_mem[rx_wr] <= bus.spi_data_out;
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q        <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_fire) timeout_err <= 1'b1;
    end
  end
`else
  // Watchdog compiled out: constant 0 for every legal TIMEOUT_CYCLES
  assign timeout_err = (TIMEOUT_CYCLES == 0);
`endif
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Randomized bench for spi_xfer_sequencer against a queue-based transfer model.
// Follows SPI_SEQ_TIMEOUT_EN to choose the expected watchdog behaviour.
module tb_spi_xfer_sequencer;
  localparam int DW = 8, DEPTH = 8, GAP = 2, TMO = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, timeout_err;
  logic [3:0] tx_level, rx_level;

  always #5 clk = ~clk;

  spi_xfer_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  spi_xfer_sequencer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .tx_level(tx_level), .rx_level(rx_level), .timeout_err(timeout_err)
  );

  int n_vec = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: bytes waiting in TX, bytes owed to the consumer, and the in-flight transfer
  logic [7:0] src[$], exp_tx[$], exp_rx[$], resp_q[$], popped[$];
  logic [7:0] resp;
  bit in_flight, tmo_exp, mute, echo, spur;
  int cyc, launch_cyc, last_end, cd, n_start, gap_seen, dmin, dmax, tx_pct, rx_pct;

  task automatic step();
    bit acc, pop, done_ok, launch_exp, tmo_now, was_rst, busy_exp;
    logic [7:0] d_out, rx_seen;
    if (src.size() > 0 && int'($urandom_range(99)) < tx_pct) begin
      bus.tx_valid = 1'b1; bus.tx_data = src[0];
    end else begin
      bus.tx_valid = 1'b0; bus.tx_data = 8'($urandom);
    end
    bus.rx_ready = int'($urandom_range(99)) < rx_pct;
    if (cd == 1) begin
      bus.spi_done = 1'b1; bus.spi_data_out = resp;
    end else begin
      bus.spi_done = spur && !in_flight && ($urandom_range(1) == 1);
      bus.spi_data_out = 8'($urandom);
    end
    was_rst    = rst;
    acc        = bus.tx_valid && bus.tx_ready;
    pop        = bus.rx_valid && bus.rx_ready;
    rx_seen    = bus.rx_data;
    d_out      = bus.spi_data_out;
    done_ok    = bus.spi_done && in_flight;
    launch_exp = !was_rst && !in_flight && (cyc - last_end >= GAP) &&
                 exp_tx.size() > 0 && exp_rx.size() < DEPTH;
    tmo_now    = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    tmo_now    = !was_rst && in_flight && !bus.spi_done && (cyc + 1 - launch_cyc == TMO);
`endif
    @(posedge clk); #1;
    cyc++;
    if (was_rst) begin
      src.delete(); exp_tx.delete(); exp_rx.delete();
      in_flight = 0; tmo_exp = 0; cd = 0; last_end = -100;
      check_eq("rst_tx_ready", bus.tx_ready, 1);
      check_eq("rst_rx_valid", bus.rx_valid, 0);
      check_eq("rst_rx_data", bus.rx_data, 0);
      check_eq("rst_spi_start", bus.spi_start, 0);
      check_eq("rst_spi_data_in", bus.spi_data_in, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_tx_level", tx_level, 0);
      check_eq("rst_rx_level", rx_level, 0);
      check_eq("rst_timeout_err", timeout_err, 0);
      return;
    end
    if (cd > 0) cd--;
    if (acc) exp_tx.push_back(src.pop_front());
    if (pop) begin popped.push_back(rx_seen); void'(exp_rx.pop_front()); end
    if (done_ok) begin exp_rx.push_back(d_out); in_flight = 0; last_end = cyc; end
    if (tmo_now) begin in_flight = 0; tmo_exp = 1; last_end = cyc; end
    check_eq("spi_start", bus.spi_start, launch_exp);
    if (launch_exp) begin
      check_eq("spi_data_in", bus.spi_data_in, exp_tx.pop_front());
      in_flight = 1; launch_cyc = cyc;
    end
    if (bus.spi_start) begin
      n_start++;
      gap_seen = cyc - last_end;
      if (!mute) begin
        cd   = int'($urandom_range(dmax, dmin));
        resp = echo ? bus.spi_data_in : (resp_q.size() > 0 ? resp_q.pop_front() : 8'($urandom));
      end
    end
    busy_exp = exp_tx.size() != 0 || in_flight || (cyc - last_end < GAP);
    check_eq("tx_level", tx_level, exp_tx.size());
    check_eq("rx_level", rx_level, exp_rx.size());
    check_eq("tx_ready", bus.tx_ready, exp_tx.size() != DEPTH);
    check_eq("rx_valid", bus.rx_valid, exp_rx.size() != 0);
    check_eq("busy", busy, busy_exp);
    check_eq("timeout_err", timeout_err, tmo_exp);
    if (exp_rx.size() > 0) check_eq("rx_data", bus.rx_data, exp_rx[0]);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s0;
    bit hit;
    bus.tx_valid = 0; bus.tx_data = 0; bus.rx_ready = 0; bus.spi_done = 0; bus.spi_data_out = 0;
    cyc = 0; last_end = -100; cd = 0; n_start = 0; gap_seen = 0; launch_cyc = 0;
    in_flight = 0; tmo_exp = 0; mute = 0; echo = 0; spur = 0; resp = 0;
    tx_pct = 100; rx_pct = 100; dmin = 3; dmax = 3;
    rst = 1; step(); step(); rst = 0;

    // Single byte: A5 out, 3C back after 18 cycles
    rx_pct = 0; dmin = 18; dmax = 18; resp_q.push_back(8'h3C); src.push_back(8'hA5);
    s0 = n_start; run(40);
    check_eq("t1_starts", n_start - s0, 1);
    check_eq("t1_data_in", bus.spi_data_in, 8'hA5);
    check_eq("t1_rx_data", bus.rx_data, 8'h3C);
    check_eq("t1_rx_valid", bus.rx_valid, 1);
    check_eq("t1_idle", busy, 0);
    rx_pct = 100; run(4);

    // Back-pressure: 10 bytes, RX stalls at 8
    rx_pct = 0; echo = 1; dmin = 1; dmax = 6; popped.delete(); s0 = n_start;
    for (int i = 0; i < 10; i++) src.push_back(8'(i));
    run(150);
    check_eq("t2_starts", n_start - s0, 8);
    check_eq("t2_rx_level", rx_level, 8);
    check_eq("t2_tx_level", tx_level, 2);
    rx_pct = 100; run(80);
    check_eq("t2_starts_all", n_start - s0, 10);
    check_eq("t2_pop_count", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++) check_eq("t2_order", popped[i], 8'(i));

    // Gap spacing with spurious spi_done outside WAIT
    echo = 0; dmin = 5; dmax = 5; spur = 1;
    src.push_back(8'h11); src.push_back(8'h22);
    run(40);
    check_eq("t3_gap", gap_seen, GAP + 1);
    spur = 0;

    // Watchdog
    rx_pct = 0; mute = 1; src.push_back(8'h55);
`ifdef SPI_SEQ_TIMEOUT_EN
    run(262);
    check_eq("t4_timeout_err", timeout_err, 1);
    check_eq("t4_rx_level", rx_level, 0);
    mute = 0; dmin = 4; dmax = 4; s0 = n_start; src.push_back(8'h66);
    run(20);
    check_eq("t4_relaunch", n_start - s0, 1);
    check_eq("t4_data_in", bus.spi_data_in, 8'h66);
`else
    run(300);
    check_eq("t4_no_timeout", timeout_err, 0);
    check_eq("t4_still_wait", busy, 1);
    mute = 0; cd = 2; resp = 8'h77;
    run(10);
    check_eq("t4_released", busy, 0);
    check_eq("t4_rx_data", bus.rx_data, 8'h77);
    dmin = 4; dmax = 4; s0 = n_start; src.push_back(8'h66);
    run(20);
    check_eq("t4_relaunch", n_start - s0, 1);
    check_eq("t4_data_in", bus.spi_data_in, 8'h66);
`endif
    rx_pct = 100; run(10);

    // Reset mid-WAIT with three bytes queued
    dmin = 30; dmax = 30;
    for (int i = 0; i < 4; i++) src.push_back(8'hC0 + 8'(i));
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = in_flight && exp_tx.size() == 3;
    end
    check_eq("t5_reach_wait", hit, 1);
    rst = 1; step(); rst = 0;
    s0 = n_start; run(40);
    check_eq("t5_no_start", n_start - s0, 0);

    // TX full-1 push coinciding with launch pop
    rx_pct = 0; echo = 1; dmin = 1; dmax = 4; popped.delete();
    for (int i = 0; i < 15; i++) src.push_back(8'h80 + 8'(i));
    run(200);
    check_eq("t6_rx_full", rx_level, 8);
    check_eq("t6_tx_7", tx_level, 7);
    src.push_back(8'h8F);
    tx_pct = 0; rx_pct = 100; step();
    tx_pct = 100; rx_pct = 0; step();
    check_eq("t6_level_held", tx_level, 7);
    check_eq("t6_launch", bus.spi_start, 1);
    rx_pct = 100; run(200);
    check_eq("t6_pop_count", popped.size(), 16);
    for (int i = 0; i < 16 && i < popped.size(); i++) check_eq("t6_order", popped[i], 8'h80 + 8'(i));

    // Random traffic
    echo = 0; dmin = 1; dmax = 12; spur = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        tx_pct = int'($urandom_range(100, 10));
        rx_pct = int'($urandom_range(100, 0));
      end
      if (src.size() < 3 && $urandom_range(3) == 0) src.push_back(8'($urandom));
      step();
    end
    tx_pct = 100; rx_pct = 100; hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      step();
      hit = src.size() == 0 && exp_tx.size() == 0 && exp_rx.size() == 0 && !in_flight;
    end
    check_eq("t7_drained", hit, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Byte-stream front end for the SPI master. Buffers outgoing bytes in a TX FIFO and issues one single-byte SPI transfer at a time over the master's start/done handshake. Pushes each received byte into an RX FIFO. Exposes valid/ready streams on the system side, so the SPI master never sees back-pressure.

## Interface
- DATA_WIDTH, 8, byte width; matches the SPI master.
- FIFO_DEPTH, 8, entries per FIFO; power of two, ≥2.
- GAP_CYCLES, 2, idle cycles enforced after each spi_done before the next spi_start; ≥2.
- TIMEOUT_CYCLES, 255, WAIT-state watchdog limit; 1..65535.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- tx_data  in  DATA_WIDTH  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_WIDTH  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data.
- spi_start  out  1  one-cycle start pulse to the master.
- spi_data_in  out  DATA_WIDTH  byte for the master; held stable between launches.
- spi_done  in  1  master completion pulse.
- spi_data_out  in  DATA_WIDTH  master receive byte; valid when spi_done=1.
- busy  out  1  state≠IDLE or TX FIFO non-empty.
- tx_level, rx_level  out  $clog2(FIFO_DEPTH)+1 each  FIFO occupancy, 0..FIFO_DEPTH.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- **FIFOs.** Both are synchronous FIFOs.
  - TX push when tx_valid&&tx_ready. RX pop when rx_valid&&rx_ready.
  - Push while full is not possible, because tx_ready=0.
  - Simultaneous push and pop in one cycle is legal at any non-full level; level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, WAIT, GAP.
- **IDLE:**
  - Launch when TX non-empty and RX not full.
  - On launch: register spi_start←1 and spi_data_in←TX head, pop TX, go to WAIT, clear the watchdog counter.
  - If RX is full, the sequencer stalls in IDLE. TX keeps accepting bytes until it is full.
- **WAIT:**
  - spi_start returns to 0 after one cycle.
  - On spi_done: push spi_data_out into RX, then go to GAP. RX space was reserved at launch because only one transfer is in flight.
  - Otherwise the watchdog increments.
- **GAP:** count GAP_CYCLES cycles, then go to IDLE.
- **Spurious spi_done** in IDLE or GAP is ignored; no RX push.
- **Watchdog:** if the counter reaches TIMEOUT_CYCLES in WAIT without spi_done:
  - set timeout_err (cleared only by rst);
  - no RX push; the byte is dropped;
  - go to GAP.
- **Reset** at any time, including mid-WAIT:
  - FIFOs flushed, FSM to IDLE, counters cleared.
  - The SPI master is not reset by this block; the system resets both together.

## Timing
- **Reset values:**
  - tx_ready=1, rx_valid=0, rx_data=0, spi_start=0, spi_data_in=0.
  - busy=0, tx_level=0, rx_level=0, timeout_err=0.
- **TX to start:** byte accepted at edge n, with the block idle and TX empty → spi_start=1 for exactly the cycle after edge n+1.
- **Done to RX:** spi_done sampled high at edge m → rx_valid=1 and rx_level incremented after edge m, if RX was empty.
- **Next launch:** earliest next spi_start high after edge m+GAP_CYCLES+1.
- **Transfer cadence:** at most one transfer in flight; spi_start never reasserts before the GAP state completes.
- **Status outputs:** tx_ready, rx_valid and the level outputs are registered state, not combinational from inputs.

## Configuration
- Macro **SPI_SEQ_TIMEOUT_EN**.
- **Defined:** the watchdog and timeout_err behave as above.
- **Undefined:**
  - no counter logic;
  - WAIT exits only on spi_done, waiting indefinitely;
  - timeout_err tied to 0;
  - TIMEOUT_CYCLES is ignored.

## Test plan
- **Single byte:** push 0xA5; the slave model returns 0x3C with spi_done 18 cycles after start → one spi_start pulse, spi_data_in=0xA5, rx_data=0x3C with rx_valid=1, busy=0 after GAP.
- **Back-pressure:** rx_ready=0, push 10 bytes 0x00..0x09 → exactly 8 transfers, rx_level=8, tx_level=2, no further spi_start. Then set rx_ready=1 → 0x08 and 0x09 are launched, and rx order is 0x00..0x09.
- **Gap spacing:** spi_done at edge m → next spi_start high exactly after edge m+3 (GAP_CYCLES=2). A spurious spi_done during GAP → rx_level unchanged.
- **Timeout (macro defined):** push 0x55, never assert spi_done → timeout_err=1 after 255 WAIT cycles, rx_level=0. A following byte 0x66 still launches.
- **Reset mid-WAIT:** rst high for 1 cycle during WAIT with tx_level=3 → next cycle all outputs at reset values, and no spi_start follows.
- **Full TX simultaneous:** with TX at FIFO_DEPTH-1, a push and a launch pop in the same cycle → tx_level stays 7, and data order is preserved.
